yin_tau_scheduler: RTL and testbench
====================================

# yin_tau_scheduler

- Sequences one `diff_module` instance through a sweep of lag values `tau = MIN_TAU..MAX_TAU` for a single analysis window.
- For each lag it re-arms the datapath, waits for completion and writes `d(tau)` to a result RAM port.
- Tracks the minimum `d(tau)` and its lag.
- Sits between the frame/window manager (issues `start` with the window base address) and the pitch-decision stage (consumes `best_tau`, `best_value` and the stored `d(tau)` curve).

## Interface

Parameters:
- `TAU_WIDTH`, 6: width of lag values.
- `MIN_TAU`, 1: first lag evaluated.
- `MAX_TAU`, 40: last lag evaluated (inclusive; 40 ≈ 20 ms); must be ≤ 2^TAU_WIDTH−1 and ≥ MIN_TAU.
- `ADDR_WIDTH`, 16: sample memory address width.
- `ACC_WIDTH`, 39: width of `diff_module` accumulator result.

Ports (one clock; reset is asynchronous and active-high, named `clk` and `reset`):
- `clk`  in  1  system clock.
- `reset`  in  1  async active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancels a sweep in progress.
- `window_address`  in  ADDR_WIDTH  base address of the window; latched on accepted `start`.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `diff_reset`  out  1  drives `diff_module.reset`.
- `diff_tau`  out  TAU_WIDTH  drives `diff_module.tau`.
- `diff_initial_address`  out  ADDR_WIDTH  drives `diff_module.initial_address`.
- `diff_ready`  in  1  `diff_module.ready`.
- `diff_accumulator`  in  ACC_WIDTH  `diff_module.accumulator`.
- `res_we`  out  1  result RAM write strobe.
- `res_addr`  out  TAU_WIDTH  result RAM address (equals tau).
- `res_data`  out  ACC_WIDTH  `d(tau)` value.
- `best_tau`  out  TAU_WIDTH  lag of minimum `d(tau)` in the last completed sweep.
- `best_value`  out  ACC_WIDTH  that minimum.

## Operation

States:
- **IDLE**
  - `diff_reset`=1, `busy`=0.
  - `start`=1 → latch `window_address`, set `tau`=MIN_TAU, clear the running minimum to all-ones, go to LOAD.
- **LOAD**
  - `diff_reset`=1, `diff_tau`=`tau`.
  - Stay until `diff_ready`==0; minimum one cycle. Then → RUN.
- **RUN**
  - `diff_reset`=0.
  - Wait for `diff_ready`==1 → SETTLE.
- **SETTLE**
  - Exactly one cycle; the accumulator is valid one cycle after `ready` rises.
  - → STORE.
- **STORE**
  - One cycle: `res_we`=1, `res_addr`=`tau`, `res_data`=`diff_accumulator`.
  - If `diff_accumulator` < running minimum (strict, so ties keep the lower tau), update the minimum and its lag.
  - If `tau`==MAX_TAU → DONE; else `tau`++ → LOAD.
- **DONE**
  - One cycle: `done`=1.
  - Copy the running minimum/lag to `best_value`/`best_tau`.
  - → IDLE.

Rules:
- `diff_tau` and `diff_initial_address` are stable from LOAD through STORE.
- `abort` in any non-IDLE state → IDLE next cycle.
  - No `done` pulse; `best_*` unchanged.
  - Already-written RAM entries remain.
- `abort` and `start` both high in IDLE: `start` is ignored.
- `start` while busy: ignored.
- Tau never wraps: the increment happens only when `tau` < MAX_TAU.

Reset values:
- IDLE, `busy`=0, `done`=0, `diff_reset`=1.
- `diff_tau`=0, `diff_initial_address`=0.
- `res_we`=0, `res_addr`=0, `res_data`=0.
- `best_tau`=0, `best_value`=all-ones.

Reset mid-sweep: immediate return to the reset state.

## Timing

- `busy` rises the cycle after `start` is sampled.
- Per-lag cost: LOAD (≥1) + RUN (datapath latency L) + SETTLE (1) + STORE (1).
- Total sweep: (MAX_TAU−MIN_TAU+1)·(L+3) + 2 cycles, with 1-cycle LOAD.
- `res_we` is a single-cycle registered pulse per lag; writes are strictly ascending in tau.
- `best_*` update in the same cycle `done` is high and hold until the next completed sweep.
- All outputs are registered; there is no combinational path from `diff_ready` or `diff_accumulator` to outputs.

## Structure

- Package `yin_pkg`: state enum (IDLE, LOAD, RUN, SETTLE, STORE, DONE), default `TAU_WIDTH`/`ADDR_WIDTH`/`ACC_WIDTH`, the `MAX_TAU` constant, and the all-ones accumulator constant.
- Sub-module `yin_min_tracker`:
  - Inputs: `clk`, `reset`, `clear`, `valid`, `value`, `tag`.
  - Outputs: running min value and tag; strict-less-than update.
- Top level holds the FSM, the tau counter and the `best_*` output registers.

## Test plan

1. Behavioral diff model with L=16 and `d(tau)`=100−tau, MIN_TAU=1, MAX_TAU=4 → RAM writes (1,99),(2,98),(3,97),(4,96) in order; `done` once; `best_tau`=4, `best_value`=96.
2. `d(tau)`={5,2,2,9} for tau 1..4 → `best_tau`=2 (tie keeps lowest), `best_value`=2.
3. Model holds `ready` high for 3 cycles after `diff_reset` rises → scheduler stays in LOAD until `ready` drops; each `res_data` equals the value presented one cycle after `ready` rose.
4. `abort` during RUN at tau=3 → `busy` low next cycle; no `done`; `best_*` keep previous-sweep values; 2 writes seen.
5. `start` pulsed while busy, and `start`+`abort` together in IDLE → both ignored; a single sweep completes, with no extra `done`.
6. Async `reset` asserted mid-STORE → all outputs at reset values before the next `clk` edge; a subsequent `start` produces a full, correct sweep.

Source files
------------

// File: rtl/yin_pkg.sv
// yin_pkg: shared states and default widths for the YIN lag scheduler
package yin_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, STORE, DONE} state_t;
  localparam int DEF_TAU_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 39;
  localparam int DEF_MAX_TAU = 40;
  localparam logic [DEF_ACC_WIDTH-1:0] ACC_ONES = '1;
endpackage

// File: rtl/yin_min_tracker.sv
// yin_min_tracker: running strict-less-than minimum of value with its tag
module yin_min_tracker #(
  parameter int W = 39,
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          valid,
  input  logic [W-1:0]  value,
  input  logic [TW-1:0] tag,
  output logic [W-1:0]  min_value,
  output logic [TW-1:0] min_tag
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      min_value <= '1;
      min_tag <= '0;
    end else if (valid && value < min_value) begin
      min_value <= value;
      min_tag <= tag;
    end
  end
endmodule

// File: rtl/yin_tau_scheduler.sv
// yin_tau_scheduler: sweeps diff_module over tau, stores d(tau), tracks the minimum
module yin_tau_scheduler
  import yin_pkg::*;
#(
  parameter int TAU_WIDTH = DEF_TAU_WIDTH,
  parameter int MIN_TAU = 1,
  parameter int MAX_TAU = DEF_MAX_TAU,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] window_address,
  output logic                  busy,
  output logic                  done,
  output logic                  diff_reset,
  output logic [TAU_WIDTH-1:0]  diff_tau,
  output logic [ADDR_WIDTH-1:0] diff_initial_address,
  input  logic                  diff_ready,
  input  logic [ACC_WIDTH-1:0]  diff_accumulator,
  output logic                  res_we,
  output logic [TAU_WIDTH-1:0]  res_addr,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic [TAU_WIDTH-1:0]  best_tau,
  output logic [ACC_WIDTH-1:0]  best_value
);
  state_t state, next;
  logic [ACC_WIDTH-1:0] min_value;
  logic [TAU_WIDTH-1:0] min_tag;
  logic last_tau;
  assign last_tau = diff_tau == TAU_WIDTH'(MAX_TAU);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start && !abort ? LOAD : IDLE;
      LOAD:    next = !diff_ready ? RUN : LOAD;
      RUN:     next = diff_ready ? SETTLE : RUN;
      SETTLE:  next = STORE;
      STORE:   next = last_tau ? DONE : LOAD;
      default: next = IDLE;
    endcase
    if (abort && state != IDLE) next = IDLE;
  end
  yin_min_tracker #(.W(ACC_WIDTH), .TW(TAU_WIDTH)) u_min (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE && next == LOAD),
    .valid(state == SETTLE && next == STORE),
    .value(diff_accumulator),
    .tag(diff_tau),
    .min_value(min_value),
    .min_tag(min_tag)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      diff_reset <= 1'b1;
      diff_tau <= '0;
      diff_initial_address <= '0;
      res_we <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      best_tau <= '0;
      best_value <= '1;
    end else begin
      state <= next;
      busy <= next != IDLE;
      done <= next == DONE;
      diff_reset <= next == IDLE || next == LOAD || next == DONE;
      res_we <= next == STORE;
      if (state == IDLE && next == LOAD) begin
        diff_tau <= TAU_WIDTH'(MIN_TAU);
        diff_initial_address <= window_address;
      end
      if (state == STORE && next == LOAD) diff_tau <= diff_tau + 1'b1;
      if (next == STORE) begin
        res_addr <= diff_tau;
        res_data <= diff_accumulator;
      end
      if (next == DONE) begin
        best_tau <= min_tag;
        best_value <= min_value;
      end
    end
  end
endmodule

// File: tb/tb_yin_tau_scheduler.sv
// tb_yin_tau_scheduler: table-driven and directed checks of the tau sweep scheduler
module tb_yin_tau_scheduler;
  localparam int TW = 6, AW = 16, CW = 39;
  localparam logic [CW-1:0] GARB = 39'h12_3456_789A;
  localparam logic [CW-1:0] ONES = '1;
  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic [AW-1:0] window_address = '0;
  logic busy, done, diff_reset, res_we, diff_ready;
  logic [TW-1:0] diff_tau, res_addr, best_tau;
  logic [AW-1:0] diff_initial_address;
  logic [CW-1:0] diff_accumulator, res_data, best_value;
  int total = 0, bad = 0;
  yin_tau_scheduler #(.TAU_WIDTH(TW), .MIN_TAU(1), .MAX_TAU(4), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .window_address(window_address),
    .busy(busy), .done(done), .diff_reset(diff_reset), .diff_tau(diff_tau),
    .diff_initial_address(diff_initial_address), .diff_ready(diff_ready),
    .diff_accumulator(diff_accumulator), .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data), .best_tau(best_tau), .best_value(best_value)
  );
  always #5 clk = ~clk;
  logic [CW-1:0] dval [0:7];
  int lat = 16, hold_n = 0, cnt = 0, hold_cnt = 0;
  logic ready_r = 0;
  logic [CW-1:0] acc_r = GARB;
  assign diff_ready = ready_r;
  assign diff_accumulator = acc_r;
  always @(posedge clk) begin
    if (diff_reset) begin
      cnt <= 0;
      ready_r <= hold_cnt != 0;
      hold_cnt <= hold_cnt != 0 ? hold_cnt - 1 : 0;
      acc_r <= GARB;
    end else begin
      cnt <= cnt + 1;
      ready_r <= cnt >= lat - 1;
      hold_cnt <= hold_n;
      acc_r <= (ready_r && cnt >= lat) ? dval[diff_tau] : GARB;
    end
  end
  logic [TW-1:0] wt [$];
  logic [CW-1:0] wd [$];
  int done_cnt = 0;
  logic [TW-1:0] tau_at_done;
  logic [CW-1:0] val_at_done;
  always @(posedge clk) begin
    #1;
    if (res_we) begin
      wt.push_back(res_addr);
      wd.push_back(res_data);
    end
    if (done) begin
      done_cnt++;
      tau_at_done = best_tau;
      val_at_done = best_value;
    end
  end
  typedef struct packed {
    logic [3:0][CW-1:0] d;
    logic [TW-1:0] et;
    logic [CW-1:0] ev;
    logic [3:0] hold;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic clear_mon();
    wt.delete();
    wd.delete();
    done_cnt = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 64'(busy), 64'd0);
  endtask
  task automatic check_reset_vals(input string name);
    chk({name, "_busy"}, 64'(busy), 0);
    chk({name, "_done"}, 64'(done), 0);
    chk({name, "_diff_reset"}, 64'(diff_reset), 1);
    chk({name, "_diff_tau"}, 64'(diff_tau), 0);
    chk({name, "_diff_addr"}, 64'(diff_initial_address), 0);
    chk({name, "_res_we"}, 64'(res_we), 0);
    chk({name, "_res_addr"}, 64'(res_addr), 0);
    chk({name, "_res_data"}, 64'(res_data), 0);
    chk({name, "_best_tau"}, 64'(best_tau), 0);
    chk({name, "_best_value"}, 64'(best_value), 64'(ONES));
  endtask
  task automatic run_vec(input vec_t v, input logic [AW-1:0] wa, input string name);
    for (int i = 0; i < 4; i++) dval[i+1] = v.d[i];
    hold_n = int'(v.hold);
    window_address = wa;
    clear_mon();
    pulse_start();
    chk({name, "_busy_rise"}, 64'(busy), 1);
    chk({name, "_win_addr"}, 64'(diff_initial_address), 64'(wa));
    wait_idle(name);
    chk({name, "_nwrites"}, 64'(wt.size()), 4);
    for (int i = 0; i < 4 && i < wt.size(); i++) begin
      chk($sformatf("%s_wtau%0d", name, i), 64'(wt[i]), 64'(i + 1));
      chk($sformatf("%s_wdata%0d", name, i), 64'(wd[i]), 64'(v.d[i]));
    end
    chk({name, "_done_cnt"}, 64'(done_cnt), 1);
    chk({name, "_tau_at_done"}, 64'(tau_at_done), 64'(v.et));
    chk({name, "_val_at_done"}, 64'(val_at_done), 64'(v.ev));
    repeat (3) @(negedge clk);
    chk({name, "_best_tau"}, 64'(best_tau), 64'(v.et));
    chk({name, "_best_value"}, 64'(best_value), 64'(v.ev));
  endtask
  initial begin
    logic [TW-1:0] pt;
    logic [CW-1:0] pv;
    vecs[0] = '{d: {39'd96, 39'd97, 39'd98, 39'd99}, et: 6'd4, ev: 39'd96, hold: 4'd0};
    vecs[1] = '{d: {39'd9, 39'd2, 39'd2, 39'd5}, et: 6'd2, ev: 39'd2, hold: 4'd0};
    vecs[2] = '{d: {39'd40, 39'd30, 39'd20, 39'd10}, et: 6'd1, ev: 39'd10, hold: 4'd3};
    vecs[3] = '{d: {39'd7, 39'd7, 39'd7, 39'd7}, et: 6'd1, ev: 39'd7, hold: 4'd0};
    vecs[4] = '{d: {39'd3, 39'd60, 39'd3, 39'd50}, et: 6'd2, ev: 39'd3, hold: 4'd2};
    for (int i = 0; i < 8; i++) dval[i] = GARB;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) run_vec(vecs[k], AW'(16'h1000 + k), $sformatf("vec%0d", k));
    // abort during RUN at tau 3
    pt = best_tau;
    pv = best_value;
    dval[1] = 10; dval[2] = 20; dval[3] = 30; dval[4] = 40;
    hold_n = 0;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (diff_tau == 3 && !diff_reset) break;
      @(negedge clk);
    end
    chk("abort_reach_run3", 64'(diff_tau == 3 && !diff_reset), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_diff_reset", 64'(diff_reset), 1);
    repeat (5) @(negedge clk);
    chk("abort_done", 64'(done_cnt), 0);
    chk("abort_nwrites", 64'(wt.size()), 2);
    chk("abort_best_tau", 64'(best_tau), 64'(pt));
    chk("abort_best_value", 64'(best_value), 64'(pv));
    // start while busy, then start+abort in idle
    dval[1] = 8; dval[2] = 6; dval[3] = 7; dval[4] = 5;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (wt.size() >= 2) break;
      @(negedge clk);
    end
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle("busy_start");
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("sa_busy", 64'(busy), 0);
    repeat (5) @(negedge clk);
    chk("sa_busy_later", 64'(busy), 0);
    chk("bs_done_cnt", 64'(done_cnt), 1);
    chk("bs_nwrites", 64'(wt.size()), 4);
    for (int i = 0; i < 4 && i < wt.size(); i++) chk($sformatf("bs_wtau%0d", i), 64'(wt[i]), 64'(i + 1));
    chk("bs_best_tau", 64'(best_tau), 4);
    chk("bs_best_value", 64'(best_value), 5);
    // async reset mid-STORE
    clear_mon();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (res_we) break;
      @(negedge clk);
    end
    chk("mid_store_seen", 64'(res_we), 1);
    reset = 1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_vec(vecs[1], 16'h2222, "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
